// File: rtl/decoder_pkg.sv
// decoder_pkg: shared direction encoding and one-hot helper for the sequenced decoder
package decoder_pkg;
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;
  function automatic logic [31:0] onehot(input int unsigned idx);
    return 32'd1 << idx;
  endfunction
endpackage

// File: rtl/decoder_n.sv
// decoder_n: combinational W-to-2**W binary-to-one-hot decoder
module decoder_n
  import decoder_pkg::*;
#(
  parameter int W = 2
) (
  input  logic [W-1:0]      i_idx,
  output logic [(2**W)-1:0] o_one_hot
);
  always_comb begin
    o_one_hot = '0;
    o_one_hot[i_idx] = 1'b1;
  end
endmodule

// File: rtl/decoder_seq_n.sv
// decoder_seq_n: registered one-hot decoder over an index that can be loaded or stepped with wrap
module decoder_seq_n
  import decoder_pkg::*;
#(
  parameter int W = 2,
  parameter int RESET_INDEX = 0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_load,
  input  logic [W-1:0]      i_binary,
  input  logic              i_step,
  input  logic              i_dir,
  input  logic              i_enable,
  output logic [(2**W)-1:0] o_one_hot,
  output logic [W-1:0]      o_binary,
  output logic              o_wrap
);
  localparam int N = 2**W;
  localparam logic [W-1:0] RST_IDX = W'(RESET_INDEX);
  localparam logic [N-1:0] RST_OH = N'(1) << RESET_INDEX;
  if (RESET_INDEX < 0 || RESET_INDEX >= N) begin : g_bad_reset_index
    $fatal(1, "decoder_seq_n: RESET_INDEX %0d out of range for W=%0d", RESET_INDEX, W);
  end
  logic [W-1:0] r_index, w_next, w_stepped;
  logic [N-1:0] r_one_hot, w_dec;
  logic         r_wrap, w_wrap, w_down;
  assign w_down = dir_e'(i_dir) == DIR_DOWN;
  assign w_stepped = w_down ? r_index - 1'b1 : r_index + 1'b1;
  always_comb begin
    w_next = i_load ? i_binary : (i_step ? w_stepped : r_index);
    w_wrap = !i_load && i_step && (w_down ? (r_index == '0) : (r_index == '1));
  end
  decoder_n #(.W(W)) m_decoder (.i_idx(w_next), .o_one_hot(w_dec));
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_index   <= RST_IDX;
      r_one_hot <= RST_OH;
      r_wrap    <= 1'b0;
    end else begin
      r_index   <= w_next;
      r_one_hot <= i_enable ? w_dec : '0;
      r_wrap    <= w_wrap;
    end
  end
  assign o_binary  = r_index;
  assign o_one_hot = r_one_hot;
  assign o_wrap    = r_wrap;
endmodule

// File: tb/tb_decoder_seq_n.sv
// tb_decoder_seq_n: directed vector table, corner sequences and randomized checks against an index model
module tb_decoder_seq_n;
  import decoder_pkg::*;
  logic       clk = 1'b0, clk_run = 1'b0;
  logic       rst = 1'b0, load = 1'b0, step = 1'b0, dir = 1'b0, en = 1'b1;
  logic [1:0] bin = 2'b00;
  logic [3:0] one_hot;
  logic [1:0] binary;
  logic       wrap;
  int errors = 0, checks = 0;
  int m_idx = 0;
  logic m_wrap = 1'b0;
  logic [31:0] m_full;

  decoder_seq_n #(.W(2), .RESET_INDEX(0)) dut (
    .i_clk(clk), .i_reset(rst), .i_load(load), .i_binary(bin), .i_step(step),
    .i_dir(dir), .i_enable(en), .o_one_hot(one_hot), .o_binary(binary), .o_wrap(wrap)
  );

  always #5 clk = clk_run ? ~clk : clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic load; logic [1:0] bin; logic step; logic dir; logic en;
    logic [1:0] e_bin; logic [3:0] e_oh; logic e_wrap;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string name, input logic [1:0] eb, input logic [3:0] eo, input logic ew);
    chk({name, ".bin"}, 32'(binary), 32'(eb));
    chk({name, ".oh"}, 32'(one_hot), 32'(eo));
    chk({name, ".wrap"}, 32'(wrap), 32'(ew));
  endtask

  task automatic drive(input logic l, input logic [1:0] b, input logic s, input logic d, input logic e);
    load = l; bin = b; step = s; dir = d; en = e;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_step(input logic l, input logic [1:0] b, input logic s, input logic d);
    if (l) begin
      m_idx = int'(b); m_wrap = 1'b0;
    end else if (s && d) begin
      m_wrap = (m_idx == 0); m_idx = (m_idx + 3) % 4;
    end else if (s) begin
      m_wrap = (m_idx == 3); m_idx = (m_idx + 1) % 4;
    end else m_wrap = 1'b0;
  endtask

  vec_t vt[$];

  initial begin
    vt = '{
      '{1,2'd0,0,0,1, 2'd0,4'b0001,0}, '{1,2'd1,0,0,1, 2'd1,4'b0010,0},
      '{1,2'd2,0,0,1, 2'd2,4'b0100,0}, '{1,2'd3,0,0,1, 2'd3,4'b1000,0},
      '{1,2'd2,0,0,1, 2'd2,4'b0100,0}, '{0,2'd0,1,0,1, 2'd3,4'b1000,0},
      '{0,2'd0,1,0,1, 2'd0,4'b0001,1}, '{0,2'd0,1,0,1, 2'd1,4'b0010,0},
      '{1,2'd0,0,0,1, 2'd0,4'b0001,0}, '{0,2'd0,1,1,1, 2'd3,4'b1000,1},
      '{0,2'd0,1,1,1, 2'd2,4'b0100,0}, '{0,2'd0,0,0,1, 2'd2,4'b0100,0},
      '{1,2'd3,0,0,1, 2'd3,4'b1000,0}, '{1,2'd1,1,0,1, 2'd1,4'b0010,0},
      '{0,2'd0,1,0,0, 2'd2,4'b0000,0}, '{0,2'd0,0,0,1, 2'd2,4'b0100,0},
      '{1,2'd3,0,0,1, 2'd3,4'b1000,0}, '{1,2'd0,1,1,1, 2'd0,4'b0001,0}
    };
    #3 rst = 1'b1;
    #1 check_all("reset_stopped_clk", 2'd0, 4'b0001, 1'b0);
    clk_run = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    foreach (vt[i]) begin
      drive(vt[i].load, vt[i].bin, vt[i].step, vt[i].dir, vt[i].en);
      check_all($sformatf("vec%0d", i), vt[i].e_bin, vt[i].e_oh, vt[i].e_wrap);
    end
    drive(1, 2'd2, 0, 0, 1);
    drive(0, 2'd0, 1, 0, 1);
    check_all("pre_reset_step", 2'd3, 4'b1000, 1'b0);
    #2 rst = 1'b1;
    #1 check_all("reset_mid_step", 2'd0, 4'b0001, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 2'd0, 1, 0, 1);
    check_all("first_after_release", 2'd1, 4'b0010, 1'b0);
    m_idx = 1; m_wrap = 1'b0;
    for (int i = 0; i < 300; i++) begin
      logic l, s, d, e;
      logic [1:0] b;
      l = ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 3) != 0);
      d = 1'($urandom);
      e = ($urandom_range(0, 4) != 0);
      b = 2'($urandom);
      drive(l, b, s, d, e);
      model_step(l, b, s, d);
      m_full = onehot(m_idx);
      check_all($sformatf("rand%0d", i), 2'(m_idx), e ? m_full[3:0] : 4'b0000, m_wrap);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
